// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Brief    : Shared types and constants for the parking barrier sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OPENING   = 2'd1,
        WAIT_PASS = 2'd2,
        CLOSING   = 2'd3
    } gate_state_t;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // 20 ms frame, 1.5 ms open pulse, 0.5 ms closed pulse at 50 MHz
    localparam int DEF_PERIOD_CYC = 1000000;
    localparam int DEF_OPEN_W     = 75000;
    localparam int DEF_CLOSE_W    = 25000;

endpackage
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_gen
// Brief    : Servo frame counter with per-frame pulse width latch.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_gen
    import parking_pkg::*;
#(
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int OPEN_W     = DEF_OPEN_W,
    parameter int CLOSE_W    = DEF_CLOSE_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic open_req,
    output logic motor,
    output logic frame_end
);

    localparam int FCW = $clog2(PERIOD_CYC + 1);

    logic [FCW-1:0] r_fc;
    logic [FCW-1:0] r_width;

    assign frame_end = (r_fc == FCW'(PERIOD_CYC - 1));

    // Width resets to zero so the servo sees no pulse until the first full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc    <= '0;
            r_width <= '0;
        end else if (frame_end) begin
            r_fc    <= '0;
            r_width <= open_req ? FCW'(OPEN_W) : FCW'(CLOSE_W);
        end else begin
            r_fc    <= r_fc + 1'b1;
        end
    end

    assign motor = (r_fc < r_width);

endmodule
`default_nettype wire

// File: rtl/gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_sequencer
// Brief    : Entry/exit barrier arbiter, phase FSM and occupancy counter.
//            Optional sensor debounce filter: define SENSOR_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gate_sequencer
    import parking_pkg::*;
#(
    parameter int PERIOD_CYC    = DEF_PERIOD_CYC,
    parameter int OPEN_W        = DEF_OPEN_W,
    parameter int CLOSE_W       = DEF_CLOSE_W,
    parameter int SETTLE_FRAMES = 25,
    parameter int HOLD_FRAMES   = 250,
    parameter int CAPACITY      = 16,
    parameter int CW            = 5,
    parameter int DEBOUNCE_CYC  = 500000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          entrada_n,
    input  logic          salida_n,
    input  logic          entrada_sal_n,
    input  logic          salida_sal_n,
    output logic          motor,
    output logic          led,
    output logic [CW-1:0] ocupados,
    output logic          gate_open,
    output logic          dir_out
);

    localparam int MAXF = (HOLD_FRAMES > SETTLE_FRAMES) ? HOLD_FRAMES : SETTLE_FRAMES;
    localparam int FRW  = $clog2(MAXF + 1);

    // Sensor bit order: entry request, exit request, entry pass, exit pass
    logic [3:0] w_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_lvl;
    logic [1:0] r_prev_pass;

    assign w_raw = {salida_sal_n, entrada_sal_n, salida_n, entrada_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SENSOR_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_sense
`ifdef SENSOR_DEBOUNCE_EN
        logic [DBW-1:0] r_cnt;
        logic           r_filt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt  <= '0;
                r_filt <= 1'b1;
            end else if (r_sync2[gi] == r_filt) begin
                r_cnt  <= '0;
            end else if (r_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
                r_cnt  <= '0;
                r_filt <= r_sync2[gi];
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end

        assign w_lvl[gi] = r_filt;
`else
        assign w_lvl[gi] = r_sync2[gi];
`endif
    end

    gate_state_t   r_state;
    gate_state_t   state_next;
    logic          r_dir;
    logic          dir_next;
    logic [CW-1:0] r_occ;
    logic          r_led;
    logic [FRW-1:0] r_frames;
    logic [FRW-1:0] w_limit;
    logic          w_frames_done;
    logic          w_frame_end;
    logic          w_req_in;
    logic          w_req_out;
    logic          w_pass;
    logic          w_inc;
    logic          w_dec;
    logic          w_open_next;

    assign w_req_in  = ~w_lvl[0] && (r_occ < CW'(CAPACITY));
    assign w_req_out = ~w_lvl[1] && (r_occ != '0);

    // Only the pass sensor belonging to the direction being served counts.
    assign w_pass = (r_dir == DIR_IN) ? (r_prev_pass[0] & ~w_lvl[2])
                                      : (r_prev_pass[1] & ~w_lvl[3]);

    assign w_limit       = (r_state == WAIT_PASS) ? FRW'(HOLD_FRAMES - 1)
                                                  : FRW'(SETTLE_FRAMES - 1);
    assign w_frames_done = w_frame_end && (r_frames == w_limit);

    always_comb begin
        state_next = r_state;
        dir_next   = r_dir;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_in && w_req_out) begin
                    state_next = OPENING;
                    dir_next   = ~r_dir;
                end else if (w_req_in) begin
                    state_next = OPENING;
                    dir_next   = DIR_IN;
                end else if (w_req_out) begin
                    state_next = OPENING;
                    dir_next   = DIR_OUT;
                end
            end
            OPENING: begin
                if (w_frames_done) state_next = WAIT_PASS;
            end
            WAIT_PASS: begin
                if (w_pass) begin
                    state_next = CLOSING;
                    w_inc      = (r_dir == DIR_IN);
                    w_dec      = (r_dir == DIR_OUT);
                end else if (w_frames_done) begin
                    state_next = CLOSING;
                end
            end
            CLOSING: begin
                if (w_frames_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dir       <= DIR_IN;
            r_frames    <= '0;
            r_occ       <= '0;
            r_led       <= 1'b0;
            r_prev_pass <= 2'b11;
        end else begin
            r_state     <= state_next;
            r_dir       <= dir_next;
            r_prev_pass <= w_lvl[3:2];
            r_led       <= (r_occ == CW'(CAPACITY));
            if (state_next != r_state)
                r_frames <= '0;
            else if (w_frame_end && r_state != IDLE)
                r_frames <= r_frames + 1'b1;
            if (w_inc && r_occ != CW'(CAPACITY))
                r_occ <= r_occ + 1'b1;
            else if (w_dec && r_occ != '0)
                r_occ <= r_occ - 1'b1;
        end
    end

    // The width latched at a frame boundary follows the state the new frame starts in.
    assign w_open_next = (state_next == OPENING) || (state_next == WAIT_PASS);

    servo_pwm_gen #(
        .PERIOD_CYC (PERIOD_CYC),
        .OPEN_W     (OPEN_W),
        .CLOSE_W    (CLOSE_W)
    ) u_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .open_req  (w_open_next),
        .motor     (motor),
        .frame_end (w_frame_end)
    );

    assign led       = r_led;
    assign ocupados  = r_occ;
    assign gate_open = (r_state == OPENING) || (r_state == WAIT_PASS);
    assign dir_out   = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_sequencer
// Brief    : Directed table-driven bench for gate_sequencer (small frame sizes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_sequencer;

    localparam int OW  = 15;
    localparam int CLW = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entrada_n = 1'b1;
    logic       salida_n = 1'b1;
    logic       entrada_sal_n = 1'b1;
    logic       salida_sal_n = 1'b1;
    logic       motor;
    logic       led;
    logic [4:0] ocupados;
    logic       gate_open;
    logic       dir_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit ent;
        bit sal;
        int pass;   // 0 none, 1 served pass sensor, 2 opposite pass sensor
        int open;   // expected full open-width frames, 0 = no grant
        bit dir;
        int occ;
        bit led;
    } vec_t;

    vec_t tbl[9];

    gate_sequencer #(
        .PERIOD_CYC    (100),
        .OPEN_W        (OW),
        .CLOSE_W       (CLW),
        .SETTLE_FRAMES (2),
        .HOLD_FRAMES   (5),
        .CAPACITY      (2),
        .CW            (5),
        .DEBOUNCE_CYC  (500000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .entrada_n     (entrada_n),
        .salida_n      (salida_n),
        .entrada_sal_n (entrada_sal_n),
        .salida_sal_n  (salida_sal_n),
        .motor         (motor),
        .led           (led),
        .ocupados      (ocupados),
        .gate_open     (gate_open),
        .dir_out       (dir_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the high time of the next motor pulse, or -1 if none appears.
    task automatic measure_frame(output int w);
        int n;
        w = -1;
        n = 0;
        while (motor !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        while (motor !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) return;
        w = 0;
        while (motor === 1'b1 && w < 200) begin w++; @(negedge clk); end
    endtask

    task automatic pulse_pass(input bit sel);
        if (sel) salida_sal_n = 1'b0;
        else     entrada_sal_n = 1'b0;
        wait_cycles(4);
        entrada_sal_n = 1'b1;
        salida_sal_n  = 1'b1;
    endtask

    task automatic run_row(input int i);
        vec_t v;
        int   w;
        int   cnt;
        v = tbl[i];
        measure_frame(w);
        wait_cycles(15);
        entrada_n = !v.ent;
        salida_n  = !v.sal;
        wait_cycles(4);
        check($sformatf("row%0d grant", i), int'(gate_open), int'(v.open != 0));
        if (v.open != 0) begin
            check($sformatf("row%0d dir", i), int'(dir_out), int'(v.dir));
            entrada_n = 1'b1;
            salida_n  = 1'b1;
            cnt = 0;
            for (int k = 0; k < 12; k++) begin
                measure_frame(w);
                if (w != OW) break;
                cnt++;
                if (cnt == 2 && v.pass == 1) pulse_pass(v.dir);
                if (cnt == 2 && v.pass == 2) pulse_pass(!v.dir);
            end
            check($sformatf("row%0d open_frames", i), cnt, v.open);
            check($sformatf("row%0d close_width", i), w, CLW);
        end else begin
            measure_frame(w);
            check($sformatf("row%0d idle_width", i), w, CLW);
            entrada_n = 1'b1;
            salida_n  = 1'b1;
        end
        wait_cycles(250);
        check($sformatf("row%0d ocupados", i), int'(ocupados), v.occ);
        check($sformatf("row%0d led", i), int'(led), int'(v.led));
        check($sformatf("row%0d closed", i), int'(gate_open), 0);
        if (v.open != 0)
            check($sformatf("row%0d dir_hold", i), int'(dir_out), int'(v.dir));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        //          ent   sal   pass open dir   occ led
        tbl[0] = '{1'b1, 1'b0, 1,   2,   1'b0, 1,  1'b0};  // entry with pass
        tbl[1] = '{1'b1, 1'b1, 0,   6,   1'b1, 1,  1'b0};  // first tie -> exit, timeout
        tbl[2] = '{1'b1, 1'b1, 1,   2,   1'b0, 2,  1'b1};  // second tie -> entry, lot full
        tbl[3] = '{1'b1, 1'b0, 0,   0,   1'b0, 2,  1'b1};  // entry denied while full
        tbl[4] = '{1'b0, 1'b1, 1,   2,   1'b1, 1,  1'b0};  // exit with pass
        tbl[5] = '{1'b0, 1'b1, 1,   2,   1'b1, 0,  1'b0};  // exit to empty
        tbl[6] = '{1'b0, 1'b1, 0,   0,   1'b0, 0,  1'b0};  // exit denied while empty
        tbl[7] = '{1'b1, 1'b0, 2,   6,   1'b0, 0,  1'b0};  // wrong pass sensor ignored
        tbl[8] = '{1'b1, 1'b0, 1,   2,   1'b0, 1,  1'b0};  // entry before reset test

        rst_n = 1'b0;
        wait_cycles(3);
        check("reset motor", int'(motor), 0);
        check("reset led", int'(led), 0);
        check("reset ocupados", int'(ocupados), 0);
        check("reset gate_open", int'(gate_open), 0);
        check("reset dir_out", int'(dir_out), 0);
        rst_n = 1'b1;

        measure_frame(w);
        check("idle width 1", w, CLW);
        measure_frame(w);
        check("idle width 2", w, CLW);

        for (int i = 0; i < 9; i++) run_row(i);

        // Reset in the middle of WAIT_PASS with one car inside
        measure_frame(w);
        wait_cycles(15);
        entrada_n = 1'b0;
        wait_cycles(4);
        check("rst_seq grant", int'(gate_open), 1);
        entrada_n = 1'b1;
        measure_frame(w);
        check("rst_seq open 1", w, OW);
        measure_frame(w);
        check("rst_seq open 2", w, OW);
        rst_n = 1'b0;
        #1;
        check("rst_seq motor", int'(motor), 0);
        check("rst_seq gate_open", int'(gate_open), 0);
        check("rst_seq ocupados", int'(ocupados), 0);
        check("rst_seq led", int'(led), 0);
        check("rst_seq dir_out", int'(dir_out), 0);
        wait_cycles(3);
        rst_n = 1'b1;
        measure_frame(w);
        check("rst_seq width after", w, CLW);
        check("rst_seq idle", int'(gate_open), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
